// File: rtl/control_seq_if.sv
// control_seq_if: instruction, flag and strobe bundle between the sequencer and the datapath.
interface control_seq_if #(
  parameter int DEST_W  = 3,
  parameter int SRC_W   = 3,
  parameter int COUNT_W = 16
);
  localparam int IR_W = DEST_W + SRC_W + 2;
  logic [IR_W-1:0]        rom_data_i;
  logic                   ready_i;
  logic                   resume_i;
  logic                   a_is_zero_i;
  logic                   flag_carry_i;
  logic                   flag_shift_i;
  logic [IR_W-1:0]        ir_o;
  logic                   ir_load_o;
  logic                   pc_inc_o;
  logic                   do_jump_o;
  logic [(1<<DEST_W)-1:0] load_o;
  logic [(1<<SRC_W)-1:0]  assert_o;
  logic                   do_subtract_o;
  logic                   do_shift_in_o;
  logic                   do_carry_in_o;
  logic                   halted_o;
  logic [COUNT_W-1:0]     instr_count_o;
  modport master (
    input  rom_data_i, ready_i, resume_i, a_is_zero_i, flag_carry_i, flag_shift_i,
    output ir_o, ir_load_o, pc_inc_o, do_jump_o, load_o, assert_o,
           do_subtract_o, do_shift_in_o, do_carry_in_o, halted_o, instr_count_o
  );
  modport slave (
    output rom_data_i, ready_i, resume_i, a_is_zero_i, flag_carry_i, flag_shift_i,
    input  ir_o, ir_load_o, pc_inc_o, do_jump_o, load_o, assert_o,
           do_subtract_o, do_shift_in_o, do_carry_in_o, halted_o, instr_count_o
  );
endinterface

// File: rtl/control_seq.sv
// control_seq: FETCH/EXEC/HALT sequencer owning the instruction register and retired-instruction counter.
module control_seq #(
  parameter int DEST_W  = 3,
  parameter int SRC_W   = 3,
  parameter int COUNT_W = 16
) (
  input  logic         clk,
  input  logic         resetBar,
  control_seq_if.master bus
);
  localparam int IR_W = DEST_W + SRC_W + 2;
  localparam int LD_W = 1 << DEST_W;
  localparam int AS_W = 1 << SRC_W;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t             state_q, state_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic [DEST_W-1:0]  dest;
  logic [SRC_W-1:0]   src;
  logic               b3, b7, fe, ex, nop, hlt, jmp, cond, take;
  assign {b7, dest, b3, src} = ir_q;
  // strobes only fire when the sequencer is actually advancing this cycle
  assign fe   = resetBar && bus.ready_i && state_q == FETCH;
  assign ex   = resetBar && bus.ready_i && state_q == EXEC;
  assign nop  = dest == '0;
  assign hlt  = dest == DEST_W'(1);
  assign jmp  = &dest;
  assign cond = b7 ? (b3 ? bus.flag_shift_i : bus.flag_carry_i) : (b3 ? bus.a_is_zero_i : 1'b1);
  assign take = ex && jmp && cond;
  assign bus.ir_load_o     = fe;
  assign bus.do_jump_o     = take;
  assign bus.pc_inc_o      = fe || (ex && src == '0 && !take);
  assign bus.load_o        = (ex && !nop && !hlt && !jmp) ? LD_W'(1) << dest : '0;
  assign bus.assert_o      = (ex && !nop && !hlt) ? AS_W'(1) << src : '0;
  assign bus.do_subtract_o = ex && b3;
  assign bus.do_shift_in_o = ex && b3;
  assign bus.do_carry_in_o = ex && b7;
  assign bus.ir_o          = ir_q;
  assign bus.halted_o      = halted_q;
  assign bus.instr_count_o = cnt_q;
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    if (fe) begin
      state_d = EXEC;
      ir_d    = bus.rom_data_i;
    end
    if (ex) begin
      state_d  = hlt ? HALT : FETCH;
      cnt_d    = cnt_q + COUNT_W'(1);
      halted_d = hlt;
    end
    if (state_q == HALT && bus.resume_i) begin
      state_d  = FETCH;
      halted_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end
endmodule
